fetch_stage: RTL and testbench

- Instruction-fetch stage: program counter, next-PC selection, instruction-memory addressing and the IF/ID pipeline register.
- Sits directly downstream of the hazard unit and consumes its PC_write, IF_write and addrSel outputs. It also takes a flush strobe and redirect targets from ID/EX.
- Presents the fetched instruction, its PC+4 and a valid flag to the decode stage.

---
 rtl/fetch_stage_pkg.sv | 15 +
 rtl/next_pc_mux.sv | 46 ++++
 rtl/fetch_stage.sv | 116 +++++++++++
 tb/tb_fetch_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Holds the next-PC select encodings (also used by the hazard unit) and the
// default reset PC / NOP instruction word.
package fetch_stage_pkg;

    // Next-PC select encodings driven by the hazard unit.
    localparam logic [1:0] ADDR_PC4    = 2'b00;
    localparam logic [1:0] ADDR_JUMP   = 2'b01;
    localparam logic [1:0] ADDR_BRANCH = 2'b10;
    localparam logic [1:0] ADDR_JR     = 2'b11;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC selection for the fetch stage. Purely combinational.
// Ports:
//   pc4_i           - current pc + 4
//   if_id_pc4_hi_i  - IF_ID_pc4[31:28], region bits for the J-type target
//   jump_index_i    - 26-bit J-type index of the instruction in ID
//   branch_target_i - branch target from EX
//   jr_target_i     - register target for jr
//   addr_sel_i      - next-PC select (ADDR_* encodings)
//   next_pc_o       - word-aligned next-PC candidate
//   misalign_o      - selected branch/jr target had non-zero low bits
module next_pc_mux
    import fetch_stage_pkg::*;
(
    input  logic [31:0] pc4_i,
    input  logic [3:0]  if_id_pc4_hi_i,
    input  logic [25:0] jump_index_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] jr_target_i,
    input  logic [1:0]  addr_sel_i,
    output logic [31:0] next_pc_o,
    output logic        misalign_o
);

    logic [31:0] target;

    always_comb begin
        target     = pc4_i;
        misalign_o = 1'b0;
        unique case (addr_sel_i)
            ADDR_PC4:    target = pc4_i;
            ADDR_JUMP:   target = {if_id_pc4_hi_i, jump_index_i, 2'b00};
            ADDR_BRANCH: begin
                target     = branch_target_i;
                misalign_o = |branch_target_i[1:0];
            end
            ADDR_JR: begin
                target     = jr_target_i;
                misalign_o = |jr_target_i[1:0];
            end
            default: target = pc4_i;
        endcase
        // Register targets may be misaligned; force word alignment.
        next_pc_o = {target[31:2], 2'b00};
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, instruction-memory
// addressing and the IF/ID pipeline register.
// Ports:
//   Clk, Rst            - clock, synchronous active-high reset
//   PC_write, IF_write  - hazard-unit enables for PC and IF/ID
//   IF_flush            - load NOP into IF/ID and clear valid
//   addrSel             - next-PC select (ADDR_* encodings)
//   jump_index, branch_target, jr_target - redirect targets
//   imem_addr/imem_rdata - combinational instruction-memory interface
//   pc                  - current PC
//   IF_ID_instr/pc4/valid - IF/ID pipeline register
//   addr_err            - sticky misaligned-target flag
//   fetch_count         - count of valid instructions loaded into IF/ID
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        PC_write,
    input  logic        IF_write,
    input  logic        IF_flush,
    input  logic [1:0]  addrSel,
    input  logic [25:0] jump_index,
    input  logic [31:0] branch_target,
    input  logic [31:0] jr_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] IF_ID_instr,
    output logic [31:0] IF_ID_pc4,
    output logic        IF_ID_valid,
    output logic        addr_err,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pc4_q, if_id_pc4_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic        addr_err_q, addr_err_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic [31:0] pc4;
    logic [31:0] next_pc;
    logic        misalign;

    assign pc4 = pc_q + 32'd4;

    // Jump target uses the held IF_ID_pc4, which is still the jump's own
    // PC+4 because IF/ID is frozen during the jump cycle.
    next_pc_mux u_next_pc_mux (
        .pc4_i           (pc4),
        .if_id_pc4_hi_i  (if_id_pc4_q[31:28]),
        .jump_index_i    (jump_index),
        .branch_target_i (branch_target),
        .jr_target_i     (jr_target),
        .addr_sel_i      (addrSel),
        .next_pc_o       (next_pc),
        .misalign_o      (misalign)
    );

    always_comb begin
        pc_d          = pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_valid_d = if_id_valid_q;
        addr_err_d    = addr_err_q;
        fetch_count_d = fetch_count_q;

        if (PC_write) begin
            pc_d       = next_pc;
            addr_err_d = addr_err_q | misalign;
        end

        if (IF_flush) begin
            if_id_instr_d = NOP_INSTR;
            if_id_pc4_d   = pc4;
            if_id_valid_d = 1'b0;
        end else if (IF_write) begin
            if_id_instr_d = imem_rdata;
            if_id_pc4_d   = pc4;
            if_id_valid_d = 1'b1;
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc_q          <= RESET_PC;
            if_id_instr_q <= NOP_INSTR;
            if_id_pc4_q   <= 32'd0;
            if_id_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            pc_q          <= pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_valid_q <= if_id_valid_d;
            addr_err_q    <= addr_err_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign IF_ID_instr = if_id_instr_q;
    assign IF_ID_pc4   = if_id_pc4_q;
    assign IF_ID_valid = if_id_valid_q;
    assign addr_err    = addr_err_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by
// randomized control/targets, all compared against a behavioural model.
module tb_fetch_stage;

    logic        Clk;
    logic        Rst;
    logic        PC_write;
    logic        IF_write;
    logic        IF_flush;
    logic [1:0]  addrSel;
    logic [25:0] jump_index;
    logic [31:0] branch_target;
    logic [31:0] jr_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] IF_ID_instr;
    logic [31:0] IF_ID_pc4;
    logic        IF_ID_valid;
    logic        addr_err;
    logic [31:0] fetch_count;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model state.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic        m_err;
    logic [31:0] m_count;

    fetch_stage dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .PC_write      (PC_write),
        .IF_write      (IF_write),
        .IF_flush      (IF_flush),
        .addrSel       (addrSel),
        .jump_index    (jump_index),
        .branch_target (branch_target),
        .jr_target     (jr_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .pc            (pc),
        .IF_ID_instr   (IF_ID_instr),
        .IF_ID_pc4     (IF_ID_pc4),
        .IF_ID_valid   (IF_ID_valid),
        .addr_err      (addr_err),
        .fetch_count   (fetch_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Instruction memory contents as a function of byte address.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return a ^ 32'h2000_0000;
    endfunction

    assign imem_rdata = imem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic pcw, input logic ifw, input logic fl,
                         input logic [1:0] sel, input logic [25:0] ji,
                         input logic [31:0] bt, input logic [31:0] jr);
        Rst           = rst;
        PC_write      = pcw;
        IF_write      = ifw;
        IF_flush      = fl;
        addrSel       = sel;
        jump_index    = ji;
        branch_target = bt;
        jr_target     = jr;
    endtask

    // One clock edge of the architectural behaviour, from the current inputs.
    task automatic model_step();
        logic [31:0] nxt;
        logic [31:0] seq;
        if (Rst) begin
            m_pc    = 32'h0;
            m_instr = 32'h0;
            m_pc4   = 32'h0;
            m_valid = 1'b0;
            m_err   = 1'b0;
            m_count = 32'h0;
        end else begin
            seq = m_pc + 32'd4;
            case (addrSel)
                2'd0: nxt = seq;
                2'd1: nxt = (m_pc4 & 32'hF000_0000) + {4'h0, jump_index, 2'b00};
                2'd2: nxt = branch_target;
                default: nxt = jr_target;
            endcase
            if (PC_write && addrSel >= 2'd2 && (nxt % 4) != 0) begin
                m_err = 1'b1;
                nxt   = nxt - (nxt % 4);
            end
            if (IF_flush) begin
                m_instr = 32'h0;
                m_pc4   = seq;
                m_valid = 1'b0;
            end else if (IF_write) begin
                m_instr = imem_word(m_pc);
                m_pc4   = seq;
                m_valid = 1'b1;
                m_count = m_count + 1;
            end
            if (PC_write) m_pc = nxt;
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_step();
        #1;
        check("pc", pc, m_pc);
        check("imem_addr", imem_addr, m_pc);
        check("instr", IF_ID_instr, m_instr);
        check("pc4", IF_ID_pc4, m_pc4);
        check("valid", {31'b0, IF_ID_valid}, {31'b0, m_valid});
        check("addr_err", {31'b0, addr_err}, {31'b0, m_err});
        check("count", fetch_count, m_count);
    endtask

    initial begin
        m_pc = '0; m_instr = '0; m_pc4 = '0; m_valid = 1'b0; m_err = 1'b0; m_count = '0;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 26'h0, 32'h0, 32'h0);

        // Reset for two cycles.
        tick();
        tick();
        check("rst_pc", pc, 32'h0);
        check("rst_valid", {31'b0, IF_ID_valid}, 32'd0);
        check("rst_count", fetch_count, 32'd0);

        // Free run.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 26'h0, 32'h0, 32'h0);
        tick();
        check("run_pc4", pc, 32'h4);
        check("run_instr0", IF_ID_instr, 32'h2000_0000);
        check("run_valid", {31'b0, IF_ID_valid}, 32'd1);
        tick();
        check("run_pc8", pc, 32'h8);
        check("run_instr1", IF_ID_instr, 32'h2000_0004);

        // Load stall at pc = 8.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 26'h0, 32'h0000_1234, 32'h0);
        tick();
        check("stall_pc", pc, 32'h8);
        check("stall_instr", IF_ID_instr, 32'h2000_0004);
        check("stall_count", fetch_count, 32'd2);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 26'h0, 32'h0, 32'h0);
        tick();
        check("resume_pc", pc, 32'hC);
        check("resume_count", fetch_count, 32'd3);

        // Set up IF_ID_pc4 = 0x1000_0010, then jump.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 26'h0, 32'h1000_000C, 32'h0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 26'h0, 32'h0, 32'h0);
        tick();
        check("pre_jump_pc4", IF_ID_pc4, 32'h1000_0010);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 26'h000_0040, 32'h0, 32'h0);
        tick();
        check("jump_pc", pc, 32'h1000_0100);
        check("jump_hold_pc4", IF_ID_pc4, 32'h1000_0010);

        // Branch with flush.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 26'h0, 32'h0000_0200, 32'h0);
        tick();
        check("br_pc", pc, 32'h200);
        check("br_instr", IF_ID_instr, 32'h0);
        check("br_valid", {31'b0, IF_ID_valid}, 32'd0);
        check("br_count", fetch_count, 32'd4);

        // Misaligned jr.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 26'h0, 32'h0, 32'h0000_0306);
        tick();
        check("jr_pc", pc, 32'h304);
        check("jr_err", {31'b0, addr_err}, 32'd1);

        // Aligned redirect to the top of memory; error stays set, then wrap.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 26'h0, 32'hFFFF_FFFC, 32'h0);
        tick();
        check("sticky_err", {31'b0, addr_err}, 32'd1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 26'h0, 32'h0, 32'h0);
        tick();
        check("wrap_pc", pc, 32'h0);
        check("wrap_err", {31'b0, addr_err}, 32'd1);

        // Reset mid-operation with redirect and flush asserted.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 26'h0, 32'h0000_0444, 32'h0);
        tick();
        check("mrst_pc", pc, 32'h0);
        check("mrst_err", {31'b0, addr_err}, 32'd0);
        check("mrst_count", fetch_count, 32'd0);
        check("mrst_pc4", IF_ID_pc4, 32'd0);

        // Randomized phase.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] bt;
            logic [31:0] jr;
            bt = $urandom;
            jr = $urandom;
            if ($urandom_range(0, 1) == 0) bt[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 0) jr[1:0] = 2'b00;
            drive(($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) == 0),
                  2'($urandom_range(0, 3)),
                  26'($urandom),
                  bt, jr);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
